// File: rtl/ex_md_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package ex_md_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_dp.sv
// Iterative datapath: shift-add multiply and restoring divide on operand magnitudes,
// one step per enabled cycle, with the sign fix-up applied to the step being taken.
module ex_muldiv_dp
    import ex_md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              sa, sb, neg_load;
    logic [XLEN-1:0]   a_mag, b_mag, hi_n, lo_n;
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        sa       = 1'b0;
        sb       = 1'b0;
        neg_load = 1'b0;
        case (md_op_e'(funct3))
            MD_MULH, MD_DIV: begin
                sa       = opr_a[XLEN-1];
                sb       = opr_b[XLEN-1];
                neg_load = sa ^ sb;
            end
            MD_REM: begin
                sa       = opr_a[XLEN-1];
                sb       = opr_b[XLEN-1];
                neg_load = sa;
            end
            MD_MULHSU: begin
                sa       = opr_a[XLEN-1];
                neg_load = sa;
            end
            default: ;
        endcase
        a_mag = sa ? -opr_a : opr_a;
        b_mag = sb ? -opr_b : opr_b;
    end

    // hi holds the upper product / partial remainder; lo holds multiplier bits / quotient bits.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, mcand_q};
        if (op_q[2]) begin
            if (!diff[XLEN]) begin
                hi_n = diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = shifted[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_n, lo_n} = {sum, lo_q[XLEN-1:1]};
        end
        prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        case (md_op_e'(op_q))
            MD_MUL:          result = prod[XLEN-1:0];
            MD_DIV, MD_DIVU: result = neg_q ? -lo_n : lo_n;
            MD_REM, MD_REMU: result = neg_q ? -hi_n : hi_n;
            default:         result = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        op_d    = op_q;
        neg_d   = neg_q;
        if (load) begin
            hi_d    = '0;
            lo_d    = funct3[2] ? a_mag : b_mag;
            mcand_d = funct3[2] ? b_mag : a_mag;
            op_d    = funct3;
            neg_d   = neg_load;
        end else if (step) begin
            hi_d = hi_n;
            lo_d = lo_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multi-cycle sequencer: accepts one op from ID/EX, stalls the pipe while the
// datapath iterates, then pulses done with the result for the EX result mux.
module ex_muldiv_seq
    import ex_md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_i_flush,
    input  logic            md_i_valid,
    input  logic [2:0]      md_i_funct3,
    input  logic [XLEN-1:0] md_i_opr_a,
    input  logic [XLEN-1:0] md_i_opr_b,
    output logic            md_o_stall,
    output logic            md_o_busy,
    output logic            md_o_done,
    output logic [XLEN-1:0] md_o_result
);

    localparam int              CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;
    logic [XLEN-1:0]  result_q, result_d, special_res, dp_result;
    logic             accept, dp_step, div_zero, div_ovf, special;

    assign accept = (state_q == MD_IDLE) && md_i_valid && !ex_i_flush;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        div_zero    = (md_i_opr_b == '0);
        div_ovf     = ((md_op_e'(md_i_funct3) == MD_DIV) || (md_op_e'(md_i_funct3) == MD_REM))
                      && (md_i_opr_a == SMIN) && (md_i_opr_b == '1);
        special     = md_i_funct3[2] && (div_zero || div_ovf);
        special_res = '0;
        if (div_zero)
            special_res = md_i_funct3[1] ? md_i_opr_a : '1;
        else if (div_ovf)
            special_res = md_i_funct3[1] ? '0 : SMIN;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dp_step  = 1'b0;
        if (ex_i_flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_i_valid) begin
                        if (special) begin
                            state_d  = MD_DONE;
                            result_d = special_res;
                        end else begin
                            state_d = MD_BUSY;
                            cnt_d   = CNT_W'(XLEN);
                        end
                    end
                end
                MD_BUSY: begin
                    dp_step = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = MD_DONE;
                        result_d = dp_result;
                    end
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d == MD_BUSY);
            done_q   <= (state_d == MD_DONE);
            result_q <= result_d;
        end
    end

    ex_muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (dp_step),
        .funct3 (md_i_funct3),
        .opr_a  (md_i_opr_a),
        .opr_b  (md_i_opr_b),
        .result (dp_result)
    );

    assign md_o_stall  = md_i_valid && !done_q;
    assign md_o_busy   = busy_q;
    assign md_o_done   = done_q;
    assign md_o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M cases, random ops against an
// arithmetic reference model, back-to-back issue, flush and mid-operation reset.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_i_flush = 1'b0;
    logic        md_i_valid = 1'b0;
    logic [2:0]  md_i_funct3 = '0;
    logic [31:0] md_i_opr_a = '0;
    logic [31:0] md_i_opr_b = '0;
    logic        md_o_stall, md_o_busy, md_o_done;
    logic [31:0] md_o_result;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] SMIN = 32'h8000_0000;

    always #5 clk = ~clk;

    ex_muldiv_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_i_flush  (ex_i_flush),
        .md_i_valid  (md_i_valid),
        .md_i_funct3 (md_i_funct3),
        .md_i_opr_a  (md_i_opr_a),
        .md_i_opr_b  (md_i_opr_b),
        .md_o_stall  (md_o_stall),
        .md_o_busy   (md_o_busy),
        .md_o_done   (md_o_done),
        .md_o_result (md_o_result)
    );

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] as_, au, bs, bu, p;
        as_ = {{32{a[31]}}, a};
        au  = {32'b0, a};
        bs  = {{32{b[31]}}, b};
        bu  = {32'b0, b};
        p   = '0;
        case (f)
            3'd0: begin p = au * bu;  return p[31:0];  end
            3'd1: begin p = as_ * bs; return p[63:32]; end
            3'd2: begin p = as_ * bu; return p[63:32]; end
            3'd3: begin p = au * bu;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
                p = as_ / bs; return p[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = as_ % bs; return p[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == SMIN && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the done pulse.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input bit hold);
        logic [31:0] exp_res;
        int exp_lat, cycles;
        bit seen;
        exp_res = ref_md(f, a, b);
        exp_lat = ref_latency(f, a, b);
        md_i_valid = 1'b1; md_i_funct3 = f; md_i_opr_a = a; md_i_opr_b = b;
        cycles = 0; seen = 0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            if (md_o_done) seen = 1;
            else begin
                n_checks++;
                if (md_o_stall !== 1'b1) begin
                    n_errors++; $display("FAIL stall_high op=%0d cyc=%0d got=%b want=1", f, cycles, md_o_stall);
                end
                n_checks++;
                if (md_o_busy !== (cycles > 0)) begin
                    n_errors++; $display("FAIL busy op=%0d cyc=%0d got=%b want=%b", f, cycles, md_o_busy, cycles > 0);
                end
                if (scramble && cycles > 0) begin
                    md_i_opr_a = $urandom; md_i_opr_b = $urandom;
                end
                cycles++;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++; $display("FAIL timeout op=%0d a=%h b=%h no done within 100 cycles", f, a, b);
        end else begin
            n_checks += 3;
            if (cycles != exp_lat) begin
                n_errors++; $display("FAIL latency op=%0d got=%0d want=%0d", f, cycles, exp_lat);
            end
            if (md_o_result !== exp_res) begin
                n_errors++; $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", f, a, b, md_o_result, exp_res);
            end
            if (md_o_stall !== 1'b0) begin
                n_errors++; $display("FAIL stall_done op=%0d got=%b want=0", f, md_o_stall);
            end
        end
        @(posedge clk); #1;
        if (!hold) md_i_valid = 1'b0;
        n_checks++;
        if (md_o_done !== 1'b0) begin
            n_errors++; $display("FAIL done_pulse op=%0d done still high after one cycle", f);
        end
        $display("op f3=%0d a=%h b=%h result=%h want=%h latency=%0d", f, a, b, md_o_result, exp_res, cycles);
    endtask

    task automatic watch_no_done(input string tag, input int n);
        bit bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (md_o_done !== 1'b0 || md_o_busy !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++; $display("FAIL %s spurious done/busy after abort", tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (md_o_busy !== 1'b0)   begin n_errors++; $display("FAIL reset_busy got=%b want=0", md_o_busy); end
        if (md_o_done !== 1'b0)   begin n_errors++; $display("FAIL reset_done got=%b want=0", md_o_done); end
        if (md_o_result !== 32'h0) begin n_errors++; $display("FAIL reset_result got=%h want=0", md_o_result); end
        if (md_o_stall !== 1'b0)  begin n_errors++; $display("FAIL reset_stall got=%b want=0", md_o_stall); end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset state checked");
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(3'd5, 32'd100, 32'd7, 0, 0);
        run_op(3'd7, 32'd100, 32'd7, 0, 0);
        run_op(3'd4, 32'd5, 32'd0, 0, 0);
        run_op(3'd6, 32'd5, 32'd0, 0, 0);
        run_op(3'd4, SMIN, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd6, SMIN, 32'hFFFF_FFFF, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, 32'd12345, 32'd678, 0, 1);
        run_op(3'd5, 32'd1000, 32'd33, 0, 1);
        run_op(3'd4, 32'd9, 32'd0, 0, 1);
        run_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 0, 0);
    endtask

    task automatic pick_operand(output logic [31:0] v);
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'hFFFF_FFFF;
            2: v = SMIN;
            3: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0] f;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            pick_operand(a);
            pick_operand(b);
            run_op(f, a, b, 1, ($urandom_range(0, 1) == 1));
        end
        md_i_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        run_op(3'd5, 32'd100, 32'd7, 0, 0);
        md_i_valid = 1'b1; md_i_funct3 = 3'd0; md_i_opr_a = 32'd3; md_i_opr_b = 32'd4;
        repeat (10) @(posedge clk);
        #1;
        ex_i_flush = 1'b1; md_i_valid = 1'b0;
        @(posedge clk); #1;
        ex_i_flush = 1'b0;
        n_checks++;
        if (md_o_busy !== 1'b0 || md_o_done !== 1'b0) begin
            n_errors++; $display("FAIL flush_idle busy=%b done=%b want 0/0", md_o_busy, md_o_done);
        end
        watch_no_done("flush", 40);
        n_checks++;
        if (md_o_result !== 32'd14) begin
            n_errors++; $display("FAIL flush_result got=%h want=%h", md_o_result, 32'd14);
        end
        md_i_valid = 1'b1; ex_i_flush = 1'b1;
        @(posedge clk); #1;
        md_i_valid = 1'b0; ex_i_flush = 1'b0;
        n_checks++;
        if (md_o_busy !== 1'b0 || md_o_done !== 1'b0) begin
            n_errors++; $display("FAIL flush_accept op accepted during flush busy=%b done=%b", md_o_busy, md_o_done);
        end
        watch_no_done("flush_valid", 40);
        $display("flush checked result=%h", md_o_result);
    endtask

    task automatic test_reset_mid_op();
        md_i_valid = 1'b1; md_i_funct3 = 3'd3; md_i_opr_a = 32'hDEAD_BEEF; md_i_opr_b = 32'h1234_5678;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (md_o_busy !== 1'b0)    begin n_errors++; $display("FAIL midrst_busy got=%b want=0", md_o_busy); end
        if (md_o_done !== 1'b0)    begin n_errors++; $display("FAIL midrst_done got=%b want=0", md_o_done); end
        if (md_o_result !== 32'h0) begin n_errors++; $display("FAIL midrst_result got=%h want=0", md_o_result); end
        md_i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        watch_no_done("reset", 40);
        run_op(3'd0, 32'h0001_2345, 32'hFFFF_0003, 0, 0);
        $display("mid-operation reset checked");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Multi-cycle sequencer for RV32M multiply/divide ops issued from the EX stage. It accepts an operation from the ID/EX latch, stalls the pipeline while it runs iterative shift-add or restoring-divide steps, and then presents a one-cycle result pulse. The EX result mux selects this result in place of the ALU output. It sits beside the ALU and consumes the forwarded operands (post mux3/mux4).

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ex_i_flush  in  1  EX flush from control unit; aborts any operation
md_i_valid  in  1  ID/EX holds an M-ext op; held high while md_o_stall=1
md_i_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
md_i_opr_a  in  XLEN  rs1 value after forwarding
md_i_opr_b  in  XLEN  rs2 value after forwarding
md_o_stall  out  1  freeze PC, IF/ID and ID/EX
md_o_busy  out  1  registered; high in BUSY
md_o_done  out  1  registered one-cycle pulse; result valid
md_o_result  out  XLEN  result; held until the next done

Behaviour:
- Reset (async): state=IDLE; md_o_busy=0, md_o_done=0, md_o_result=0, counter=0.
- States: IDLE, BUSY, DONE.
- IDLE: if md_i_valid & ~ex_i_flush, capture funct3 and operands.
  - Normal ops go to BUSY with counter=XLEN.
  - Special div cases go to DONE directly.
- BUSY: perform one step per cycle and decrement the counter. At counter==1, apply sign fix-up, go to DONE, and load md_o_result.
- DONE: md_o_done=1 for exactly this cycle, then return to IDLE unconditionally. The valid seen in this cycle belongs to the instruction now leaving, so it is not re-accepted.
- md_o_stall = md_i_valid & ~md_o_done (combinational).
- Latency:
  - Normal ops: accept at cycle T, done at T+XLEN+1 (33 cycles), so 33 stall cycles.
  - Special div cases: done at T+1, so 1 stall cycle.
- Multiply:
  - Operate on magnitudes over a 2*XLEN product.
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU and MUL: unsigned.
  - Negate the product when the sign flag is set.
  - MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
- Divide: restoring algorithm on magnitudes.
  - DIV/REM: signed. Quotient sign = sa^sb; remainder sign = sa.
  - DIVU/REMU: unsigned.
- Special div cases:
  - b==0: quotient = all ones; remainder = a.
  - Signed a=0x80000000, b=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Flush:
  - ex_i_flush in any state returns to IDLE on the next edge; md_o_done is not asserted and md_o_result is unchanged.
  - Flush and valid together in IDLE: the op is not accepted.
- Reset mid-operation: immediate IDLE, all outputs 0, no done pulse after release.
- Operand changes while BUSY are ignored, because the operands are captured at accept.
- No pipelining: only one op is in flight at a time.

Decomposition:
- Package ex_md_pkg: funct3 encodings (MD_MUL..MD_REMU), state enum (MD_IDLE, MD_BUSY, MD_DONE), XLEN default.
- Optional sub-module ex_muldiv_dp, the iterative datapath: accumulator/remainder, shift registers, one-step add/subtract, negation. Keep the FSM, counter and stall logic in ex_muldiv_seq.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3): result 0xFFFFFFEB. Done at T+33. md_o_stall high for 33 cycles and low in the done cycle.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF: result 0xFFFFFFFE. MULH same operands: result 0x00000000. MULHSU 0xFFFFFFFF x 2: result 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2: result 0xFFFFFFFD. REM same operands: result 0xFFFFFFFF. DIVU 100/7: result 14. REMU 100/7: result 2.
- DIV 5/0: result 0xFFFFFFFF. REM 5/0: result 5. DIV 0x80000000/0xFFFFFFFF: result 0x80000000. Each done at T+1.
- Back-to-back ops: issue two consecutive ops with valid held; each gets exactly one done pulse and there is no double accept.
- ex_i_flush at T+10 returns to IDLE at T+11 with no done pulse and result unchanged. Reset asserted at T+5 drops all outputs immediately; a new MUL after reset release completes correctly.
